hit_window_counter: RTL and testbench

//  Per-channel hit counter gated by the slow divided clock from clk_divider (gate_in).
//  One window spans one full gate_in period, rising edge to rising edge.
//  At each window boundary, all channel counts are snapshotted and streamed out one channel per beat over a valid/ready port.

---
 rtl/hit_window_counter_if.sv | 26 ++
 rtl/hit_window_counter.sv | 163 ++++++++++++++++
 tb/tb_hit_window_counter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hit_window_counter_if.sv
// Count readout stream: one channel count per beat.
// valid/ready handshake; master drives, slave accepts.
interface hit_window_counter_if #(
    parameter int N_CH    = 4,
    parameter int COUNT_W = 16,
    parameter int WID_W   = 16
);
    localparam int CH_W = $clog2(N_CH) | 1;

    logic [COUNT_W-1:0] data;
    logic [CH_W-1:0]    ch;
    logic [WID_W-1:0]   wid;
    logic               last;
    logic               valid;
    logic               ready;

    modport master (
        output data, ch, wid, last, valid,
        input  ready
    );

    modport slave (
        input  data, ch, wid, last, valid,
        output ready
    );
endinterface

// File: rtl/hit_window_counter.sv
// Per-channel hit counter windowed by gate_in rising edges.
// Optional HIT_SYNC_EN: 2-FF synchronizer on hit_in.
module hit_window_counter #(
    parameter int N_CH    = 4,
    parameter int COUNT_W = 16,
    parameter int WID_W   = 16
) (
    input  logic                clk_in,
    input  logic                aresetn,
    input  logic                gate_in,
    input  logic [N_CH-1:0]     hit_in,
    hit_window_counter_if.master m_count,
    output logic                overrun
);
    localparam int CH_W = $clog2(N_CH) | 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        DISARMED,
        IDLE,
        SEND
    } state_t;

    state_t state, state_nx;

    logic [N_CH-1:0]    hit_s;
    logic [N_CH-1:0]    hit_q;
    logic [N_CH-1:0]    hit_e;
    logic               gate_q;
    logic               boundary;
    logic [COUNT_W-1:0] live   [N_CH];
    logic [COUNT_W-1:0] shadow [N_CH];
    logic [CH_W-1:0]    ch, ch_nx;
    logic [WID_W-1:0]   wid, wid_out;
    logic               snap, adv_wid, ovr_set, hs, last;

`ifdef HIT_SYNC_EN
    (* ASYNC_REG = "TRUE" *) logic [N_CH-1:0] sync1;
    (* ASYNC_REG = "TRUE" *) logic [N_CH-1:0] sync2;

    // Two-stage synchronizer for asynchronous discriminator levels
    always_ff @(posedge clk_in or negedge aresetn) begin
        if (!aresetn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= hit_in;
            sync2 <= sync1;
        end
    end

    assign hit_s = sync2;
`else
    assign hit_s = hit_in;
`endif

    // Delay taps for hit and gate edge detection
    always_ff @(posedge clk_in or negedge aresetn) begin
        if (!aresetn) begin
            hit_q  <= '0;
            gate_q <= 1'b0;
        end else begin
            hit_q  <= hit_s;
            gate_q <= gate_in;
        end
    end

    assign hit_e    = hit_s & ~hit_q;
    assign boundary = gate_in & ~gate_q;

    // Live counters: restart on boundary with the coincident hit, else saturate
    always_ff @(posedge clk_in or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_CH; i++) live[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (boundary)
                    live[i] <= COUNT_W'(hit_e[i]);
                else if (hit_e[i] && live[i] != CNT_MAX)
                    live[i] <= live[i] + COUNT_W'(1);
            end
        end
    end

    assign hs   = (state == SEND) && m_count.ready;
    assign last = (ch == LAST_CH);

    // FSM state register
    always_ff @(posedge clk_in or negedge aresetn) begin
        if (!aresetn) state <= DISARMED;
        else          state <= state_nx;
    end

    // Next-state and control strobes
    always_comb begin
        state_nx = state;
        ch_nx    = ch;
        snap     = 1'b0;
        adv_wid  = 1'b0;
        ovr_set  = 1'b0;
        unique case (state)
            DISARMED: begin
                if (boundary) state_nx = IDLE;
            end
            IDLE: begin
                if (boundary) begin
                    snap     = 1'b1;
                    adv_wid  = 1'b1;
                    ch_nx    = '0;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (boundary) begin
                    adv_wid = 1'b1;
                    ovr_set = 1'b1;
                end
                if (hs) begin
                    if (last) begin
                        ch_nx    = '0;
                        state_nx = IDLE;
                    end else begin
                        ch_nx = ch + CH_W'(1);
                    end
                end
            end
            default: state_nx = DISARMED;
        endcase
    end

    // Snapshot, window id and sticky overrun
    always_ff @(posedge clk_in or negedge aresetn) begin
        if (!aresetn) begin
            ch      <= '0;
            wid     <= '0;
            wid_out <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < N_CH; i++) shadow[i] <= '0;
        end else begin
            ch <= ch_nx;
            if (adv_wid) wid <= wid + WID_W'(1);
            if (snap) begin
                wid_out <= wid;
                shadow  <= live;
            end
            if (ovr_set) overrun <= 1'b1;
        end
    end

    // Beat data mux from the snapshot
    always_comb begin
        m_count.data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch == CH_W'(i)) m_count.data = shadow[i];
        end
    end

    assign m_count.ch    = ch;
    assign m_count.wid   = wid_out;
    assign m_count.last  = (state == SEND) && last;
    assign m_count.valid = (state == SEND);
endmodule

// File: tb/tb_hit_window_counter.sv
// Self-checking bench for hit_window_counter.
// Window vectors in a table, beats checked via a scoreboard queue.
`timescale 1ns/1ps
module tb_hit_window_counter;
    localparam int N_CH = 4;
    localparam int CW   = 8;
    localparam int WW   = 16;
    localparam int CHW  = $clog2(N_CH) | 1;
`ifdef HIT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct packed {
        logic [9:0]       len;
        logic [3:0][9:0]  n;
        logic [3:0][7:0]  e;
        logic             rep;
        logic [15:0]      wid;
        logic [1:0]       stall_ch;
        logic [9:0]       stall_len;
        logic             bhit;
    } vec_t;

    typedef struct packed {
        logic [CW-1:0]  data;
        logic [CHW-1:0] ch;
        logic [WW-1:0]  wid;
        logic           last;
    } beat_t;

    logic            clk;
    logic            aresetn;
    logic            gate_in;
    logic [N_CH-1:0] hit_in;
    logic            overrun;

    hit_window_counter_if #(.N_CH(N_CH), .COUNT_W(CW), .WID_W(WW)) m ();

    hit_window_counter #(.N_CH(N_CH), .COUNT_W(CW), .WID_W(WW)) dut (
        .clk_in  (clk),
        .aresetn (aresetn),
        .gate_in (gate_in),
        .hit_in  (hit_in),
        .m_count (m),
        .overrun (overrun)
    );

    int    tests = 0;
    int    fails = 0;
    int    beats = 0;
    int    stall_left = 0;
    int    stall_ch = 0;
    beat_t q[$];
    beat_t held;
    beat_t cur;
    beat_t exp_b;
    logic  stalled = 1'b0;
    vec_t  vt [7];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
        end
    endtask

    function automatic vec_t mk(int len, int n0, int n1, int n2, int n3,
                                int e0, int e1, int e2, int e3,
                                bit rep, int wid, int sc, int sl, bit bh);
        vec_t v;
        v.len       = 10'(len);
        v.n[0]      = 10'(n0);
        v.n[1]      = 10'(n1);
        v.n[2]      = 10'(n2);
        v.n[3]      = 10'(n3);
        v.e[0]      = 8'(e0);
        v.e[1]      = 8'(e1);
        v.e[2]      = 8'(e2);
        v.e[3]      = 8'(e3);
        v.rep       = rep;
        v.wid       = 16'(wid);
        v.stall_ch  = 2'(sc);
        v.stall_len = 10'(sl);
        v.bhit      = bh;
        return v;
    endfunction

    // Ready driver: stall a chosen channel for a given number of cycles
    initial begin
        m.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && m.valid && int'(m.ch) == stall_ch) begin
                m.ready = 1'b0;
                stall_left--;
            end else begin
                m.ready = 1'b1;
            end
        end
    end

    // Monitor: pop scoreboard on handshake, check hold while stalled
    always @(negedge clk) begin
        if (!aresetn) begin
            stalled = 1'b0;
        end else begin
            cur = '{data: m.data, ch: m.ch, wid: m.wid, last: m.last};
            if (stalled)
                chk("hold_stable", {m.valid, cur}, {1'b1, held});
            if (m.valid && m.ready) begin
                beats++;
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got ch=%0d data=%0d wid=%0d, required no beat",
                             m.ch, m.data, m.wid);
                end else begin
                    exp_b = q.pop_front();
                    chk("beat", cur, exp_b);
                end
            end
            stalled = m.valid && !m.ready;
            held    = cur;
        end
    end

    task automatic pre_phase();
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            gate_in   = 1'b0;
            hit_in    = '0;
            hit_in[0] = (k >= 4) && ((k - 4) % 2 == 0) && ((k - 4) / 2 < 9);
        end
    endtask

    task automatic run_window(input vec_t v, input logic next_bhit);
        logic [N_CH-1:0] h;
        for (int k = 0; k < int'(v.len); k++) begin
            @(posedge clk);
            #1;
            gate_in = (k < int'(v.len) / 2);
            if (k == 0) begin
                stall_ch   = int'(v.stall_ch);
                stall_left = int'(v.stall_len);
            end
            for (int c = 0; c < N_CH; c++)
                h[c] = (k >= 4) && ((k - 4) % 2 == 0) &&
                       ((k - 4) / 2 < int'(v.n[c]));
            if (v.bhit && LAT == 0 && k == 0) h[3] = 1'b1;
            if (next_bhit && LAT > 0 && k == int'(v.len) - LAT) h[3] = 1'b1;
            hit_in = h;
        end
        if (v.rep) begin
            for (int c = 0; c < N_CH; c++)
                q.push_back('{data: v.e[c], ch: CHW'(c), wid: v.wid,
                              last: (c == N_CH - 1)});
        end
    endtask

    initial begin
        vt[0] = mk(400, 5, 0, 17, 1,  5, 0, 17, 1,  1, 0, 0, 0,   0);
        vt[1] = mk(700, 2, 300, 0, 3, 2, 255, 0, 3, 1, 1, 0, 0,   0);
        vt[2] = mk(400, 1, 2, 3, 4,   1, 2, 3, 4,   1, 2, 2, 10,  0);
        vt[3] = mk(400, 7, 7, 7, 7,   0, 0, 0, 0,   0, 0, 0, 500, 0);
        vt[4] = mk(400, 3, 1, 4, 1,   3, 1, 4, 1,   1, 4, 0, 0,   0);
        vt[5] = mk(400, 0, 0, 0, 2,   0, 0, 0, 3,   1, 5, 0, 0,   1);
        vt[6] = mk(400, 6, 0, 0, 0,   6, 0, 0, 0,   1, 6, 0, 0,   0);

        aresetn = 1'b0;
        gate_in = 1'b0;
        hit_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {m.valid, m.last, m.ch, m.wid, m.data, overrun}, 64'd0);
        aresetn = 1'b1;

        pre_phase();
        for (int i = 0; i < 7; i++) begin
            run_window(vt[i], (i < 6) ? vt[i+1].bhit : 1'b0);
            if (i == 0) chk("no_beats_first_window", 64'(beats), 64'd0);
            if (i == 2) chk("overrun_clear", 64'(overrun), 64'd0);
            if (i == 3) chk("overrun_before_b", 64'(overrun), 64'd0);
            if (i == 4) chk("overrun_set", 64'(overrun), 64'd1);
        end

        // Reset in the middle of the report of window 6
        @(posedge clk);
        #1;
        gate_in    = 1'b1;
        hit_in     = '0;
        stall_ch   = 1;
        stall_left = 3;
        begin
            int n;
            n = 0;
            while (!(m.valid && m.ch == CHW'(1)) && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("reach_ch1", 64'(n < 20), 64'd1);
        end
        aresetn = 1'b0;
        #1;
        chk("midreset_outputs",
            {m.valid, m.last, m.ch, m.wid, m.data}, 64'd0);
        chk("midreset_overrun", 64'(overrun), 64'd0);
        q.delete();
        stall_left = 0;
        gate_in    = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        aresetn = 1'b1;

        pre_phase();
        run_window(mk(400, 4, 0, 2, 9, 4, 0, 2, 9, 1, 0, 0, 0, 0), 1'b0);
        run_window(mk(400, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

        begin
            int n;
            n = 0;
            while ((q.size() != 0 || m.valid) && n < 200) begin
                @(posedge clk);
                n++;
            end
        end
        #1;
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
